// File: rtl/iccm_port_arbiter_if.sv
// Bus bundle between the ICCM port arbiter, its three sources and the ICCM macro.
interface iccm_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_wdata_i;
  logic              ld_lock_i;

  logic              r0_req_i;
  logic              r0_we_i;
  logic [ADDR_W-1:0] r0_addr_i;
  logic [DATA_W-1:0] r0_wdata_i;
  logic              r0_gnt_o;
  logic              r0_rvalid_o;
  logic [DATA_W-1:0] r0_rdata_o;

  logic              r1_req_i;
  logic              r1_we_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [DATA_W-1:0] r1_wdata_i;
  logic              r1_gnt_o;
  logic              r1_rvalid_o;
  logic [DATA_W-1:0] r1_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // Environment side: loader, requesters and SRAM model.
  modport master (
    output ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
    output r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
    input  r0_gnt_o, r0_rvalid_o, r0_rdata_o,
    output r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
    input  r1_gnt_o, r1_rvalid_o, r1_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

  // Arbiter side.
  modport slave (
    input  ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
    input  r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
    output r0_gnt_o, r0_rvalid_o, r0_rdata_o,
    input  r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
    output r1_gnt_o, r1_rvalid_o, r1_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );
endinterface

// File: rtl/iccm_port_arbiter.sv
// Single-port ICCM sharing: loader writes (absolute priority, one-entry pending
// register) plus two round-robin req/gnt/rvalid requesters.
module iccm_port_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  iccm_port_arbiter_if.slave  bus
);

  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;

  // rr_q holds the last granted index; 1 at reset so requester 0 wins the first tie.
  logic              rr_q;

  logic              resp_v_q;
  logic              resp_owner_q;
  logic              resp_we_q;

  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] data_hold_q;

  logic              gnt0;
  logic              gnt1;
  logic              issue;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i && !pend_v_q && !bus.ld_lock_i) begin
      if (bus.r0_req_i && bus.r1_req_i) begin
        gnt0 = rr_q;
        gnt1 = !rr_q;
      end else begin
        gnt0 = bus.r0_req_i;
        gnt1 = bus.r1_req_i;
      end
    end
  end

  always_comb begin
    issue      = pend_v_q || gnt0 || gnt1;
    issue_we   = 1'b0;
    issue_addr = addr_hold_q;
    issue_data = data_hold_q;
    if (pend_v_q) begin
      issue_we   = 1'b1;
      issue_addr = pend_addr_q;
      issue_data = pend_data_q;
    end else if (gnt0) begin
      issue_we   = bus.r0_we_i;
      issue_addr = bus.r0_addr_i;
      issue_data = bus.r0_wdata_i;
    end else if (gnt1) begin
      issue_we   = bus.r1_we_i;
      issue_addr = bus.r1_addr_i;
      issue_data = bus.r1_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (bus.ld_we_i) begin
      // A strobe in the issue cycle simply refills; the old entry leaves this cycle.
      pend_v_q    <= 1'b1;
      pend_addr_q <= bus.ld_addr_i;
      pend_data_q <= bus.ld_wdata_i;
    end else begin
      pend_v_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= 1'b1;
      resp_v_q     <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_we_q    <= 1'b0;
      addr_hold_q  <= '0;
      data_hold_q  <= '0;
    end else begin
      resp_v_q <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        rr_q         <= gnt1;
        resp_owner_q <= gnt1;
        resp_we_q    <= issue_we;
      end
      if (issue) begin
        addr_hold_q <= issue_addr;
        data_hold_q <= issue_data;
      end
    end
  end

  always_comb begin
    bus.r0_gnt_o    = gnt0;
    bus.r1_gnt_o    = gnt1;
    bus.mem_req_o   = issue;
    bus.mem_we_o    = issue && issue_we;
    bus.mem_addr_o  = issue_addr;
    bus.mem_wdata_o = issue_data;
    bus.r0_rvalid_o = resp_v_q && !resp_owner_q;
    bus.r1_rvalid_o = resp_v_q && resp_owner_q;
    bus.r0_rdata_o  = (resp_v_q && !resp_owner_q && !resp_we_q) ? bus.mem_rdata_i : '0;
    bus.r1_rdata_o  = (resp_v_q && resp_owner_q && !resp_we_q) ? bus.mem_rdata_i : '0;
  end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares the single-port ICCM SRAM between three sources: the UART program loader, requester 0 (instruction fetch) and requester 1 (DMA/debug).
- Loader writes take absolute priority and have no backpressure. They pass through a one-entry pending register.
- Requesters 0 and 1 use a req/gnt/rvalid handshake and are served round-robin.
- Sits between the loader FSM, the core-side ICCM clients and the ICCM macro.

Parameters:
ADDR_W, 14, word address width (matches the loader address)
DATA_W, 32, data width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
ld_we_i  in  1  loader write strobe; single-cycle pulse, cannot be stalled
ld_addr_i  in  ADDR_W  loader write address
ld_wdata_i  in  DATA_W  loader write data
ld_lock_i  in  1  high while programming; blocks all requester grants
r0_req_i  in  1  requester 0 request
r0_we_i  in  1  requester 0 write enable
r0_addr_i  in  ADDR_W  requester 0 address
r0_wdata_i  in  DATA_W  requester 0 write data
r0_gnt_o  out  1  requester 0 grant (combinational)
r0_rvalid_o  out  1  requester 0 response valid
r0_rdata_o  out  DATA_W  requester 0 read data
r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_gnt_o, r1_rvalid_o, r1_rdata_o  same directions, widths and meanings for requester 1
mem_req_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  ADDR_W  SRAM address
mem_wdata_o  out  DATA_W  SRAM write data
mem_rdata_i  in  DATA_W  SRAM read data; valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values:
  - pending register: valid 0, address 0, data 0
  - round-robin pointer rr_q = 1, so requester 0 wins the first tie
  - response registers cleared; all rvalid and rdata outputs = 0
  - mem_req_o and mem_we_o = 0
  - r0_gnt_o and r1_gnt_o forced to 0 while rst_i is high
- Loader path:
  - ld_we_i captures ld_addr_i and ld_wdata_i into the pending register at the next edge.
  - The pending register is issued to the SRAM in the following cycle with mem_we_o = 1.
  - Latency from strobe to SRAM write: exactly 1 cycle.
- Pending refill: the pending entry is always issued in the cycle it is valid. If ld_we_i arrives in that same cycle, the register refills with the new entry (stays valid). Back-to-back strobes therefore produce back-to-back writes. Overflow is impossible.
- Arbitration, evaluated each cycle in priority order:
  1. Pending loader write valid: issue it; no grants.
  2. ld_lock_i high: no grants; mem_req_o = 0.
  3. Exactly one requester has req high: grant it.
  4. Both requesters have req high: grant the one that is not rr_q.
- rr_q updates to the granted index on every requester grant.
- A granted request drives mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o in the same cycle as its gnt.
- Handshake:
  - A requester holds req and its command fields stable until it sees gnt.
  - A grant is a single-cycle acceptance.
  - A requester can be granted in consecutive cycles.
- Response:
  - rvalid pulses for 1 cycle, exactly one cycle after every grant (read or write), on the granted requester only.
  - rdata = mem_rdata_i for reads and 0 for writes.
  - The response owner and we flag are registered at grant time.
- Memory outputs when idle: mem_req_o = 0, mem_we_o = 0, address and data held at their last values.
- Loader write while a requester read response is outstanding: the response is still delivered in the next cycle, because the SRAM read data is already captured.
- Reset mid-operation: the pending loader write is discarded and in-flight responses are dropped; no rvalid after reset.
- Full throughput: one SRAM access per cycle, with no idle cycles between different winners.

Test Plan:
- Reset release, r0 reads address 0x0010, SRAM returns 0xDEADBEEF:
  - r0_gnt_o = 1 in the same cycle, mem_addr_o = 0x0010, mem_we_o = 0
  - next cycle r0_rvalid_o = 1 with rdata 0xDEADBEEF; r1_rvalid_o = 0
- Both requesters hold req for 4 cycles right after reset: grant order r0, r1, r0, r1, with rvalid following each grant by 1 cycle.
- Loader strobe with address 0x0002 and data 0x12345678 while both requesters hold req:
  - next cycle mem_we_o = 1 with that address and data; both gnt = 0 in that cycle
  - round-robin order then resumes from the stored pointer
- Loader strobes in 3 consecutive cycles (addresses 0x0, 0x2, 0x4): 3 consecutive SRAM writes 1 cycle later, in order; no requester grant in those cycles.
- ld_lock_i held high with r0_req_i high for 10 cycles: r0_gnt_o = 0 and mem_req_o = 0 throughout; r0 is granted in the first cycle after the lock drops.
- rst_i asserted in the cycle after an r1 read grant while a loader entry is pending:
  - r1_rvalid_o never pulses and no SRAM write occurs
  - after release, the first tie goes to r0
